// File: rtl/param_universal_shift_reg.sv
// param_universal_shift_reg: universal shift register (hold/load/shift/rotate/ASR) with an N-step burst engine
module param_universal_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             shift_r,
  input  logic             shift_l,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CW-1:0]    amt,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);
  localparam logic [2:0] M_SHR = 3'b001, M_SHL = 3'b010, M_LOAD = 3'b011,
                         M_ROR = 3'b100, M_ROL = 3'b101, M_ASR = 3'b110;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             shift_mode;
  function automatic logic [WIDTH-1:0] step_f(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                              input logic sr, input logic sl, input logic [WIDTH-1:0] ld);
    return m == M_SHR  ? {sr, v[WIDTH-1:1]} :
           m == M_SHL  ? {v[WIDTH-2:0], sl} :
           m == M_ROR  ? {v[0], v[WIDTH-1:1]} :
           m == M_ROL  ? {v[WIDTH-2:0], v[WIDTH-1]} :
           m == M_ASR  ? {v[WIDTH-1], v[WIDTH-1:1]} :
           m == M_LOAD ? ld : v;
  endfunction
  assign shift_mode = mode inside {M_SHR, M_SHL, M_ROR, M_ROL, M_ASR};
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (busy_q) begin
      q_d   = step_f(mode_q, q_q, shift_r, shift_l, d);
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (start && shift_mode) begin
      mode_d = mode;
      cnt_d  = amt;
      busy_d = amt != '0;
      done_d = amt == '0;
    end else if (en) begin
      q_d = step_f(mode, q_q, shift_r, shift_l, d);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      cnt_q  <= '0;
      mode_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign q         = q_q;
  assign ser_out_r = q_q[0];
  assign ser_out_l = q_q[WIDTH-1];
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_param_universal_shift_reg.sv
// tb_param_universal_shift_reg: directed and random checks of the shift register against an arithmetic model
module tb_param_universal_shift_reg;
  logic       clk = 1'b0;
  logic       rst, en, shift_r, shift_l, start;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] amt;
  logic [7:0] q;
  logic       ser_out_r, ser_out_l, busy, done;
  int         passed = 0, total = 0;
  logic [7:0] qm;
  int         rem;
  logic [2:0] bmode;
  logic       donem;
  param_universal_shift_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .shift_r(shift_r), .shift_l(shift_l),
    .d(d), .start(start), .amt(amt), .q(q), .ser_out_r(ser_out_r), .ser_out_l(ser_out_l),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] op(input logic [2:0] m, input logic [7:0] v, input logic sr,
                                    input logic sl, input logic [7:0] dd);
    int x = int'(v);
    case (m)
      3'd1: return 8'(x / 2 + int'(sr) * 128);
      3'd2: return 8'((x * 2) % 256 + int'(sl));
      3'd3: return dd;
      3'd4: return 8'(x / 2 + (x % 2) * 128);
      3'd5: return 8'((x * 2) % 256 + x / 128);
      3'd6: return 8'(x / 2 + (x >= 128 ? 128 : 0));
      default: return v;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic check_all();
    chk("q", q, qm);
    chk("busy", 8'(busy), 8'(rem > 0));
    chk("done", 8'(done), 8'(donem));
    chk("ser_out_r", 8'(ser_out_r), 8'(qm[0]));
    chk("ser_out_l", 8'(ser_out_l), 8'(qm[7]));
  endtask
  task automatic cyc();
    logic [7:0] nq = qm;
    if (rem > 0) begin
      nq = op(bmode, qm, shift_r, shift_l, d);
      rem--;
      donem = rem == 0;
    end else if (start && mode inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) begin
      bmode = mode;
      rem = int'(amt);
      donem = amt == 0;
    end else begin
      donem = 1'b0;
      if (en) nq = op(mode, qm, shift_r, shift_l, d);
    end
    @(posedge clk);
    #1;
    qm = nq;
    check_all();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    qm = 8'h00;
    rem = 0;
    donem = 1'b0;
    check_all();
    #2;
    rst = 1'b0;
  endtask
  task automatic load(input logic [7:0] v);
    en = 1'b1; mode = 3'd3; d = v; start = 1'b0;
    cyc();
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'd0; shift_r = 1'b0; shift_l = 1'b0;
    d = 8'h00; start = 1'b0; amt = 4'd0;
    qm = 8'h00; rem = 0; donem = 1'b0; bmode = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    load(8'h5A);
    chk("load_5a", q, 8'h5A);
    en = 1'b0;
    do_reset();
    chk("rst_async_q", q, 8'h00);
    load(8'hA5);
    chk("load_a5", q, 8'hA5);
    mode = 3'd1; shift_r = 1'b1; cyc();
    chk("shr", q, 8'hD2);
    load(8'hA5);
    mode = 3'd2; shift_l = 1'b0; cyc();
    chk("shl", q, 8'h4A);
    load(8'h81);
    mode = 3'd5; cyc();
    chk("rol", q, 8'h03);
    load(8'h81);
    mode = 3'd4; cyc();
    chk("ror", q, 8'hC0);
    load(8'h80);
    mode = 3'd6; cyc();
    chk("asr1", q, 8'hC0);
    cyc();
    chk("asr2", q, 8'hE0);
    load(8'h01);
    en = 1'b0; start = 1'b1; mode = 3'd4; amt = 4'd3; cyc();
    chk("burst_e0_q", q, 8'h01);
    chk("burst_e0_busy", 8'(busy), 8'd1);
    start = 1'b0; en = 1'b1; mode = 3'd3; d = 8'hFF; cyc();
    chk("burst_1", q, 8'h80);
    d = 8'h00; start = 1'b1; amt = 4'd9; cyc();
    chk("burst_2", q, 8'h40);
    en = 1'b0; start = 1'b0; cyc();
    chk("burst_3", q, 8'h20);
    chk("burst_done", 8'(done), 8'd1);
    chk("burst_busy_off", 8'(busy), 8'd0);
    cyc();
    chk("done_pulse_end", 8'(done), 8'd0);
    start = 1'b1; mode = 3'd1; amt = 4'd0; cyc();
    chk("amt0_done", 8'(done), 8'd1);
    chk("amt0_busy", 8'(busy), 8'd0);
    chk("amt0_q", q, 8'h20);
    start = 1'b0; cyc();
    start = 1'b1; mode = 3'd3; amt = 4'd4; cyc();
    chk("start_load_busy", 8'(busy), 8'd0);
    chk("start_load_done", 8'(done), 8'd0);
    load(8'hFF);
    en = 1'b0; start = 1'b1; mode = 3'd2; amt = 4'd5; shift_l = 1'b0; cyc();
    start = 1'b0; cyc(); cyc();
    chk("shl_burst_2", q, 8'hFC);
    do_reset();
    cyc();
    chk("no_done_after_rst", 8'(done), 8'd0);
    load(8'h3C);
    chk("post_rst_load", q, 8'h3C);
    for (int i = 0; i < 400; i++) begin
      en = 1'($urandom); mode = 3'($urandom); d = 8'($urandom);
      shift_r = 1'($urandom); shift_l = 1'($urandom);
      start = ($urandom % 4) == 0; amt = 4'($urandom);
      if ($urandom % 60 == 0) do_reset();
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
